// File: rtl/reg_40_pkg.sv
// Shared definitions for the 40-entry register file and its write scheduler.
package reg_40_pkg;

    localparam int NUM_WORDS = 40;
    localparam int ADDR_W    = 6;
    localparam int CNT_W     = 16;
    localparam int WORD_W    = 64;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } wr_entry_t;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(NUM_WORDS);
    endfunction

endpackage

// File: rtl/reg_40_wr_sched_fifo.sv
// Two-entry request FIFO for one write channel; entry 0 is always the head.
module wr_sched_fifo2
    import reg_40_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [ADDR_W-1:0]      push_addr,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [1:0]             count,
    output logic                   head_valid,
    output logic [ADDR_W-1:0]      head_addr,
    output logic [WIDTH-1:0]       head_data,
    output logic [1:0]             ent_valid,
    output logic [1:0][ADDR_W-1:0] ent_addr
);

    logic [1:0][ADDR_W-1:0] addr_q;
    logic [1:0][WIDTH-1:0]  data_q;
    logic                   accept;
    logic                   do_pop;

    assign accept = push && (count != 2'd2);
    assign do_pop = pop && (count != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            if (do_pop) begin
                addr_q[0] <= addr_q[1];
                data_q[0] <= data_q[1];
            end
            // A push into a one-entry FIFO that is popping lands straight in the head slot.
            if (accept) begin
                if (count == 2'd0 || (count == 2'd1 && do_pop)) begin
                    addr_q[0] <= push_addr;
                    data_q[0] <= push_data;
                end else begin
                    addr_q[1] <= push_addr;
                    data_q[1] <= push_data;
                end
            end
            case ({accept, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_valid = (count != 2'd0);
    assign head_addr  = addr_q[0];
    assign head_data  = data_q[0];
    assign ent_valid  = {count == 2'd2, count != 2'd0};
    assign ent_addr   = addr_q;

endmodule

// File: rtl/reg_40_wr_sched.sv
// Write-side scheduler for the dual-write-port register file.
// Build option: REG_WR_SCHED_HAZARD_EN enables the read-after-write hazard compare.
module reg_40_wr_sched
    import reg_40_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [ADDR_W-1:0] in0_addr,
    input  logic [WIDTH-1:0]  in0_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [ADDR_W-1:0] in1_addr,
    input  logic [WIDTH-1:0]  in1_data,
    output logic              wr0_en,
    output logic [ADDR_W-1:0] wr0_addr,
    output logic [WIDTH-1:0]  wr0_data,
    output logic              wr1_en,
    output logic [ADDR_W-1:0] wr1_addr,
    output logic [WIDTH-1:0]  wr1_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_hazard,
    output logic              oob_err,
    output logic [CNT_W-1:0]  collision_cnt,
    output logic              idle
);

    logic [1:0]             cnt0, cnt1;
    logic                   h0_valid, h1_valid;
    logic [ADDR_W-1:0]      h0_addr, h1_addr;
    logic [WIDTH-1:0]       h0_data, h1_data;
    logic [1:0]             ev0, ev1;
    logic [1:0][ADDR_W-1:0] ea0, ea1;
    logic                   push0, push1, pop0, pop1;
    logic                   rng0, rng1, disc0, disc1;
    logic                   collide, prio;

    wr_sched_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
        .clk        (clk),
        .rst        (rst),
        .push       (push0),
        .push_addr  (in0_addr),
        .push_data  (in0_data),
        .pop        (pop0),
        .count      (cnt0),
        .head_valid (h0_valid),
        .head_addr  (h0_addr),
        .head_data  (h0_data),
        .ent_valid  (ev0),
        .ent_addr   (ea0)
    );

    wr_sched_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
        .clk        (clk),
        .rst        (rst),
        .push       (push1),
        .push_addr  (in1_addr),
        .push_data  (in1_data),
        .pop        (pop1),
        .count      (cnt1),
        .head_valid (h1_valid),
        .head_addr  (h1_addr),
        .head_data  (h1_data),
        .ent_valid  (ev1),
        .ent_addr   (ea1)
    );

    // Readiness ignores a same-cycle pop so a full FIFO never accepts.
    assign in0_ready = (cnt0 != 2'd2);
    assign in1_ready = (cnt1 != 2'd2);
    assign push0     = in0_valid && in0_ready;
    assign push1     = in1_valid && in1_ready;

    assign rng0    = h0_valid && in_range(h0_addr);
    assign rng1    = h1_valid && in_range(h1_addr);
    assign disc0   = h0_valid && !in_range(h0_addr);
    assign disc1   = h1_valid && !in_range(h1_addr);
    assign collide = rng0 && rng1 && (h0_addr == h1_addr);

    // prio=0 lets channel 0 win a collision, prio=1 lets channel 1 win.
    assign wr0_en   = rng0 && !(collide && prio);
    assign wr1_en   = rng1 && !(collide && !prio);
    assign wr0_addr = h0_addr;
    assign wr0_data = h0_data;
    assign wr1_addr = h1_addr;
    assign wr1_data = h1_data;

    assign pop0 = wr0_en || disc0;
    assign pop1 = wr1_en || disc1;
    assign idle = (cnt0 == 2'd0) && (cnt1 == 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio          <= 1'b0;
            collision_cnt <= '0;
            oob_err       <= 1'b0;
        end else begin
            oob_err <= disc0 || disc1;
            if (collide) begin
                prio <= !prio;
                if (collision_cnt != {CNT_W{1'b1}})
                    collision_cnt <= collision_cnt + 1'b1;
            end
        end
    end

`ifdef REG_WR_SCHED_HAZARD_EN
    always_comb begin
        rd_hazard = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (ev0[i] && in_range(ea0[i]) && (ea0[i] == rd_addr))
                rd_hazard = 1'b1;
            if (ev1[i] && in_range(ea1[i]) && (ea1[i] == rd_addr))
                rd_hazard = 1'b1;
        end
    end
`else
    logic unused_hazard;
    assign rd_hazard     = 1'b0;
    assign unused_hazard = ^{rd_addr, ev0, ea0, ev1, ea1};
`endif

endmodule
